// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, the pixel coordinate type and the helpers
// that derive totals and sync windows from porch/sync widths.
package vga_timing_pkg;

  // Width of every raster coordinate (column and line).
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Total length of one axis: visible + front porch + sync + back porch.
  function automatic int axis_total(input int vis, input int fp, input int sync_w, input int bp);
    return vis + fp + sync_w + bp;
  endfunction

  // First coordinate of the sync pulse on an axis.
  function automatic int sync_first(input int vis, input int fp);
    return vis + fp;
  endfunction

  // Last coordinate (inclusive) of the sync pulse on an axis.
  function automatic int sync_last(input int vis, input int fp, input int sync_w);
    return vis + fp + sync_w - 1;
  endfunction

  // Inclusive window test on unsigned coordinates.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // 640x480 @ 60 Hz defaults with a 50 MHz system clock.
  localparam int DEF_CLK_DIV   = 2;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL      = axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = axis_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = sync_first(DEF_H_VISIBLE, DEF_H_FP);
  localparam int H_SYNC_END   = sync_last(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC);
  localparam int V_SYNC_START = sync_first(DEF_V_VISIBLE, DEF_V_FP);
  localparam int V_SYNC_END   = sync_last(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Generic modulo-N axis counter. Advances only when enabled and reports the
// enabled step that takes it from N-1 back to 0. The next-state value is
// exported so the parent can register decodes aligned with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int N = H_TOTAL
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_en,
  output coord_t o_count,
  output coord_t o_count_next,
  output logic   o_wrap
);

  coord_t r_count;
  coord_t w_next;
  logic   w_at_max;

  assign w_at_max = (r_count == coord_t'(N - 1));
  assign o_wrap   = i_en & w_at_max;

  // Next count: hold when idle, wrap N-1 -> 0, otherwise increment.
  always_comb begin
    w_next = r_count;
    if (i_en) begin
      if (w_at_max) w_next = '0;
      else          w_next = r_count + coord_t'(1);
    end
  end

  // Count register, cleared synchronously.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_count <= '0;
    else       r_count <= w_next;
  end

  assign o_count      = r_count;
  assign o_count_next = w_next;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing producer: divides Clk down to the pixel rate, runs the
// column/line counters and registers hs/vs/blank/frame_start from the
// next-state counters so every output changes on the same Clk edge.
// CLK_DIV must be even and at least 2 for vga_clk to have a 50% duty.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       vga_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HTOT    = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int VTOT    = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int HS_LO   = sync_first(H_VISIBLE, H_FP);
  localparam int HS_HI   = sync_last(H_VISIBLE, H_FP, H_SYNC);
  localparam int VS_LO   = sync_first(V_VISIBLE, V_FP);
  localparam int VS_HI   = sync_last(V_VISIBLE, V_FP, V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             w_pixel_tick;

  coord_t w_x;
  coord_t w_y;
  coord_t w_x_next;
  coord_t w_y_next;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_v_en;

  logic   r_vga_clk;
  logic   r_blank;
  logic   r_hs;
  logic   r_vs;
  logic   r_frame_start;

  // One pixel lasts CLK_DIV system clocks; the tick marks its last clock.
  assign w_pixel_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_div_next   = w_pixel_tick ? '0 : (r_div_cnt + DIV_W'(1));

  // Pixel-rate divider.
  always_ff @(posedge Clk) begin
    if (Reset) r_div_cnt <= '0;
    else       r_div_cnt <= w_div_next;
  end

  // Column counter steps once per pixel.
  vga_axis_counter #(
    .N (HTOT)
  ) u_h_cnt (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_en         (w_pixel_tick),
    .o_count      (w_x),
    .o_count_next (w_x_next),
    .o_wrap       (w_h_wrap)
  );

  // Line counter steps only when the column wraps.
  assign w_v_en = w_pixel_tick & w_h_wrap;

  vga_axis_counter #(
    .N (VTOT)
  ) u_v_cnt (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_en         (w_v_en),
    .o_count      (w_y),
    .o_count_next (w_y_next),
    .o_wrap       (w_v_wrap)
  );

  // Registered decodes of the next-state counters; vga_clk is high for the
  // second half of each pixel so DrawX/DrawY are settled at its rising edge.
  // The v-counter wrap already implies the (last col, last line) position,
  // so it doubles as the frame boundary strobe. Reset overrides a wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vga_clk     <= 1'b0;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_vga_clk     <= (w_div_next >= DIV_W'(CLK_DIV / 2));
      r_blank       <= (w_x_next < coord_t'(H_VISIBLE)) && (w_y_next < coord_t'(V_VISIBLE));
      r_hs          <= ~in_window(w_x_next, coord_t'(HS_LO), coord_t'(HS_HI));
      r_vs          <= ~in_window(w_y_next, coord_t'(VS_LO), coord_t'(VS_HI));
      r_frame_start <= w_v_wrap;
    end
  end

  assign vga_clk     = r_vga_clk;
  assign DrawX       = w_x;
  assign DrawY       = w_y;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign sync        = 1'b0;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share Clk/Reset: one with the
// 640x480 defaults (line-level timing) and one with a tiny raster so several
// whole frames fit in a short run. Expected values come from an arithmetic
// model indexed by the number of Clk edges since reset released.
module tb_vga_timing_gen;

  // Small raster used for frame-level behaviour.
  localparam int S_CD  = 4;
  localparam int S_HV  = 16;
  localparam int S_HFP = 2;
  localparam int S_HSY = 4;
  localparam int S_HBP = 3;
  localparam int S_VV  = 8;
  localparam int S_VFP = 2;
  localparam int S_VSY = 2;
  localparam int S_VBP = 3;
  localparam int S_HT  = S_HV + S_HFP + S_HSY + S_HBP;
  localparam int S_VT  = S_VV + S_VFP + S_VSY + S_VBP;
  localparam int S_FRAME = S_HT * S_VT * S_CD;

  localparam int W = 26;

  typedef struct {
    int n;
    bit win;
  } tag_t;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #10 Clk = ~Clk;

  logic       b_vga_clk, s_vga_clk;
  logic [9:0] b_x, b_y, s_x, s_y;
  logic       b_blank, b_hs, b_vs, b_sync, b_fs;
  logic       s_blank, s_hs, s_vs, s_sync, s_fs;

  vga_timing_gen u_big (
    .Clk (Clk), .Reset (Reset), .vga_clk (b_vga_clk), .DrawX (b_x), .DrawY (b_y),
    .blank (b_blank), .hs (b_hs), .vs (b_vs), .sync (b_sync), .frame_start (b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV (S_CD), .H_VISIBLE (S_HV), .H_FP (S_HFP), .H_SYNC (S_HSY), .H_BP (S_HBP),
    .V_VISIBLE (S_VV), .V_FP (S_VFP), .V_SYNC (S_VSY), .V_BP (S_VBP)
  ) u_small (
    .Clk (Clk), .Reset (Reset), .vga_clk (s_vga_clk), .DrawX (s_x), .DrawY (s_y),
    .blank (s_blank), .hs (s_hs), .vs (s_vs), .sync (s_sync), .frame_start (s_fs)
  );

  // ---------------- reference model ----------------
  // State after the n-th edge following reset release (n = 0: reset edge).
  function automatic logic [W-1:0] model(input bit rst, input int n, input int cd,
      input int hv, input int hfp, input int hsy, input int hbp,
      input int vv, input int vfp, input int vsy, input int vbp);
    int ht, vt, p, x, y;
    logic vclk, bl, h, v, fs;
    if (rst) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht   = hv + hfp + hsy + hbp;
    vt   = vv + vfp + vsy + vbp;
    p    = n / cd;
    x    = p % ht;
    y    = (p / ht) % vt;
    vclk = (n % cd) >= (cd / 2);
    fs   = (n > 0) && (n % (ht * vt * cd) == 0);
    bl   = (x < hv) && (y < vv);
    h    = !((x >= hv + hfp) && (x < hv + hfp + hsy));
    v    = !((y >= vv + vfp) && (y < vv + vfp + vsy));
    return {vclk, 10'(x), 10'(y), bl, h, v, 1'b0, fs};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("vclk=%b x=%0d y=%0d blank=%b hs=%b vs=%b sync=%b fs=%b",
                     v[25], v[24:15], v[14:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_big_q[$];
  logic [W-1:0] exp_sml_q[$];
  tag_t         tag_big_q[$];
  tag_t         tag_sml_q[$];

  int tests = 0;
  int fails = 0;
  int n_edge = 0;
  bit win = 1'b0;

  int blank_cnt = 0;
  int hs_falls  = 0;
  int vs_falls  = 0;
  int fs_cnt    = 0;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;

  // ---------------- driver ----------------
  task automatic step(input bit rst);
    @(negedge Clk);
    Reset = rst;
    @(posedge Clk);
    if (rst) n_edge = 0;
    else     n_edge = n_edge + 1;
    exp_big_q.push_back(model(rst, n_edge, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    exp_sml_q.push_back(model(rst, n_edge, S_CD, S_HV, S_HFP, S_HSY, S_HBP,
                              S_VV, S_VFP, S_VSY, S_VBP));
    tag_big_q.push_back('{n: n_edge, win: 1'b0});
    tag_sml_q.push_back('{n: n_edge, win: win && !rst && n_edge >= 1 && n_edge <= 2 * S_FRAME});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0);
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    tag_t t;
    if (exp_sml_q.size() > 0) begin
      e   = exp_sml_q.pop_front();
      t   = tag_sml_q.pop_front();
      got = {s_vga_clk, s_x, s_y, s_blank, s_hs, s_vs, s_sync, s_fs};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL small_edge n=%0d got %s need %s", t.n, fmt(got), fmt(e));
      end
      if (t.win) begin
        if (s_blank === 1'b1) blank_cnt++;
        if (prev_hs === 1'b1 && s_hs === 1'b0) hs_falls++;
        if (prev_vs === 1'b1 && s_vs === 1'b0) vs_falls++;
        if (s_fs === 1'b1) fs_cnt++;
      end
      prev_hs = s_hs;
      prev_vs = s_vs;
    end
    if (exp_big_q.size() > 0) begin
      e   = exp_big_q.pop_front();
      t   = tag_big_q.pop_front();
      got = {b_vga_clk, b_x, b_y, b_blank, b_hs, b_vs, b_sync, b_fs};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL big_edge n=%0d got %s need %s", t.n, fmt(got), fmt(e));
      end
    end
  end

  task automatic check_int(input string name, input int got, input int need);
    tests++;
    if (got != need) begin
      fails++;
      $display("FAIL %s got %0d need %0d", name, got, need);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1;
    hold_reset(3);

    // Two full small frames plus two full default lines, undisturbed;
    // blank/sync/frame_start counts are gathered over the small frames.
    win = 1'b1;
    run(3400);
    win = 1'b0;

    // Random mid-frame resets of random length.
    for (int k = 0; k < 6; k++) begin
      hold_reset($urandom_range(1, 3));
      run($urandom_range(200, 4000));
    end

    // Reset lands exactly on the small raster's frame-wrap edge.
    hold_reset(2);
    run(S_FRAME - 1);
    hold_reset(1);
    run(S_FRAME + 50);

    // Long final stretch from a clean reset.
    hold_reset(1);
    run(3300);

    @(negedge Clk);
    @(negedge Clk);
    check_int("exp_queues_drained", exp_big_q.size() + exp_sml_q.size(), 0);
    check_int("blank_cycles_2frames", blank_cnt, S_HV * S_VV * 2 * S_CD);
    check_int("hs_pulses_2frames", hs_falls, 2 * S_VT);
    check_int("vs_pulses_2frames", vs_falls, 2);
    check_int("frame_start_pulses_2frames", fs_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
